// File: rtl/comb_eval_pkg.sv
// Shared types and constants for the comb_eval arbiter slice.
// Requester IDs, output-register FSM states and the statistics counter width.
package comb_eval_pkg;

  localparam logic ID_A   = 1'b0;
  localparam logic ID_B   = 1'b1;
  localparam int   STAT_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_e;

  // Saturating increment for the grant counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] value);
    return (value == {STAT_W{1'b1}}) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/msb_eval_unit.sv
// Combinational evaluator: zero-extended sum, MSB of the truncated sum,
// and unsigned greater-than of the two operands.
module msb_eval_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic [WIDTH:0]   sum,
  output logic             msb,
  output logic             gt
);

  always_comb begin
    sum = {1'b0, op1} + {1'b0, op2};
    msb = sum[WIDTH-1];
    gt  = (op1 > op2);
  end

endmodule

// File: rtl/comb_eval_arbiter.sv
// Round-robin arbiter sharing one registered msb_eval_unit between requesters A and B.
// Define ARB_STATS_EN to enable the saturating per-requester grant counters.
module comb_eval_arbiter
  import comb_eval_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [WIDTH-1:0]  a_num1,
  input  logic [WIDTH-1:0]  a_num2,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [WIDTH-1:0]  num1,
  input  logic [WIDTH-1:0]  num2,
  output logic              b_ready,
  output logic              res_valid,
  input  logic              res_ready,
  output logic              res_id,
  output logic [WIDTH:0]    res_sum,
  output logic              res_msb,
  output logic              res_gt,
  output logic [STAT_W-1:0] grant_cnt_a,
  output logic [STAT_W-1:0] grant_cnt_b
);

  arb_state_e       state_reg, state_next;
  logic             prio_reg;
  logic             res_id_reg;
  logic [WIDTH:0]   res_sum_reg;
  logic             res_msb_reg;
  logic             res_gt_reg;

  logic             slot_free;
  logic             grant_a, grant_b, grant_any;
  logic [WIDTH-1:0] op1_mux, op2_mux;
  logic [WIDTH:0]   eval_sum;
  logic             eval_msb, eval_gt;

  assign slot_free = (state_reg == EMPTY) || res_ready;

  // Grant decision and FSM next state; reset suppresses any grant.
  always_comb begin
    grant_a    = 1'b0;
    grant_b    = 1'b0;
    state_next = state_reg;
    if (!rst && slot_free) begin
      if (a_valid && (!b_valid || prio_reg == ID_A)) begin
        grant_a = 1'b1;
      end else if (b_valid) begin
        grant_b = 1'b1;
      end
    end
    case (state_reg)
      EMPTY: if (grant_a || grant_b) state_next = FULL;
      FULL: begin
        if (grant_a || grant_b)  state_next = FULL;
        else if (res_ready)      state_next = EMPTY;
      end
      default: state_next = EMPTY;
    endcase
  end

  assign grant_any = grant_a || grant_b;
  assign a_ready   = grant_a;
  assign b_ready   = grant_b;

  assign op1_mux = grant_b ? num1 : a_num1;
  assign op2_mux = grant_b ? num2 : a_num2;

  msb_eval_unit #(
    .WIDTH (WIDTH)
  ) u_eval (
    .op1 (op1_mux),
    .op2 (op2_mux),
    .sum (eval_sum),
    .msb (eval_msb),
    .gt  (eval_gt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= EMPTY;
      prio_reg    <= ID_A;
      res_id_reg  <= 1'b0;
      res_sum_reg <= '0;
      res_msb_reg <= 1'b0;
      res_gt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (grant_any) begin
        res_id_reg  <= grant_b ? ID_B : ID_A;
        res_sum_reg <= eval_sum;
        res_msb_reg <= eval_msb;
        res_gt_reg  <= eval_gt;
        // Pointer moves to the loser so the other side is favoured next time.
        prio_reg    <= grant_a ? ID_B : ID_A;
      end
    end
  end

  assign res_valid = (state_reg == FULL);
  assign res_id    = res_id_reg;
  assign res_sum   = res_sum_reg;
  assign res_msb   = res_msb_reg;
  assign res_gt    = res_gt_reg;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt_a_reg, cnt_b_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_a_reg <= '0;
      cnt_b_reg <= '0;
    end else begin
      if (grant_a) cnt_a_reg <= sat_inc(cnt_a_reg);
      if (grant_b) cnt_b_reg <= sat_inc(cnt_b_reg);
    end
  end

  assign grant_cnt_a = cnt_a_reg;
  assign grant_cnt_b = cnt_b_reg;
`else
  assign grant_cnt_a = '0;
  assign grant_cnt_b = '0;
`endif

endmodule

// File: tb/tb_comb_eval_arbiter.sv
// Self-checking bench for comb_eval_arbiter: reference model plus result scoreboard.
// Counter expectations follow ARB_STATS_EN the same way the design build does.
module tb_comb_eval_arbiter;

  logic       clk;
  logic       rst;
  logic       a_valid, b_valid, a_ready, b_ready;
  logic [3:0] a_num1, a_num2, num1, num2;
  logic       res_valid, res_ready, res_id, res_msb, res_gt;
  logic [4:0] res_sum;
  logic [7:0] grant_cnt_a, grant_cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  logic       m_full, m_prio;
  logic [7:0] m_cnt_a, m_cnt_b;
  logic       exp_ar, exp_br;
  logic [7:0] exp_pack;
  logic [7:0] sb[$];

  comb_eval_arbiter #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .a_valid     (a_valid),
    .a_num1      (a_num1),
    .a_num2      (a_num2),
    .a_ready     (a_ready),
    .b_valid     (b_valid),
    .num1        (num1),
    .num2        (num2),
    .b_ready     (b_ready),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_id      (res_id),
    .res_sum     (res_sum),
    .res_msb     (res_msb),
    .res_gt      (res_gt),
    .grant_cnt_a (grant_cnt_a),
    .grant_cnt_b (grant_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] dut_pack();
    return {res_id, res_sum, res_msb, res_gt};
  endfunction

  function automatic logic [7:0] ref_eval(input logic id, input logic [3:0] x, input logic [3:0] y);
    logic [4:0] s;
    s = {1'b0, x} + {1'b0, y};
    return {id, s, s[3], (x > y)};
  endfunction

  // Apply inputs for one cycle and predict the handshake from the model.
  task automatic drive(input logic r, input logic av, input logic [3:0] a1, input logic [3:0] a2,
                       input logic bv, input logic [3:0] b1, input logic [3:0] b2, input logic rr);
    logic sf;
    rst = r; a_valid = av; a_num1 = a1; a_num2 = a2;
    b_valid = bv; num1 = b1; num2 = b2; res_ready = rr;
    sf     = !m_full || rr;
    exp_ar = !r && sf && av && (!bv || m_prio == 1'b0);
    exp_br = !r && sf && bv && !exp_ar;
    exp_pack = exp_br ? ref_eval(1'b1, b1, b2) : ref_eval(1'b0, a1, a2);
    #1;
  endtask

  // Clock edge, then advance the model with the inputs that were sampled.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      m_full = 1'b0; m_prio = 1'b0; m_cnt_a = '0; m_cnt_b = '0;
      sb.delete();
    end else begin
      if (m_full && res_ready && sb.size() > 0) void'(sb.pop_front());
      if (exp_ar || exp_br) begin
        sb.push_back(exp_pack);
        m_full = 1'b1;
        m_prio = exp_ar ? 1'b1 : 1'b0;
`ifdef ARB_STATS_EN
        if (exp_ar && m_cnt_a != 8'hFF) m_cnt_a = m_cnt_a + 8'd1;
        if (exp_br && m_cnt_b != 8'hFF) m_cnt_b = m_cnt_b + 8'd1;
`endif
      end else if (res_ready) begin
        m_full = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 4'd1, 4'd1, 1'b1, 4'd2, 4'd2, 1'b1);
    n_tests++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_fail++; $display("FAIL reset_ready: got %b%b want 00", a_ready, b_ready);
    end
    tick();
    tick();
    n_tests++;
    if ({res_valid, res_id, res_sum, res_msb, res_gt} !== 9'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b id=%b sum=%h msb=%b gt=%b want all 0",
                         res_valid, res_id, res_sum, res_msb, res_gt);
    end
    n_tests++;
    if ({grant_cnt_a, grant_cnt_b} !== 16'd0) begin
      n_fail++; $display("FAIL reset_counters: got %0d/%0d want 0/0", grant_cnt_a, grant_cnt_b);
    end
    $display("[TB] reset: outputs and counters cleared");
  endtask

  task automatic test_single();
    drive(1'b0, 1'b1, 4'd1, 4'd2, 1'b0, 4'd0, 4'd0, 1'b1);
    n_tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_fail++; $display("FAIL single_ready: got %b%b want 10", a_ready, b_ready);
    end
    tick();
    n_tests++;
    if (res_valid !== 1'b1 || dut_pack() !== {1'b0, 5'd3, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL single_result: got v=%b pack=%h want v=1 pack=%h",
                         res_valid, dut_pack(), {1'b0, 5'd3, 1'b0, 1'b0});
    end
    $display("[TB] single: A 1+2 -> id=%b sum=%0d", res_id, res_sum);
  endtask

  task automatic test_carry();
    logic [3:0] x [2];
    logic [3:0] y [2];
    logic [7:0] want [2];
    x[0] = 4'hF; y[0] = 4'h1; want[0] = {1'b1, 5'h10, 1'b0, 1'b1};
    x[1] = 4'h4; y[1] = 4'h4; want[1] = {1'b1, 5'h08, 1'b1, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, x[i], y[i], 1'b1);
      n_tests++;
      if ({a_ready, b_ready} !== 2'b01) begin
        n_fail++; $display("FAIL carry_ready[%0d]: got %b%b want 01", i, a_ready, b_ready);
      end
      tick();
      n_tests++;
      if (res_valid !== 1'b1 || dut_pack() !== want[i] || dut_pack() !== sb[0]) begin
        n_fail++; $display("FAIL carry_result[%0d]: got v=%b pack=%h want pack=%h", i, res_valid, dut_pack(), want[i]);
      end
      $display("[TB] carry: B %h+%h -> sum=%h msb=%b gt=%b", x[i], y[i], res_sum, res_msb, res_gt);
    end
  endtask

  task automatic test_contention();
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b1);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 4'(i), 4'd3, 1'b1, 4'(i + 7), 4'd2, 1'b1);
      n_tests++;
      if ((a_ready ^ b_ready) !== 1'b1 || a_ready !== exp_ar) begin
        n_fail++; $display("FAIL contention_ready[%0d]: got %b%b want %b%b", i, a_ready, b_ready, exp_ar, exp_br);
      end
      tick();
      n_tests++;
      if (res_id !== 1'(i % 2) || dut_pack() !== sb[0]) begin
        n_fail++; $display("FAIL contention_result[%0d]: got id=%b pack=%h want id=%0d pack=%h",
                           i, res_id, dut_pack(), i % 2, sb[0]);
      end
      $display("[TB] contention[%0d]: id=%b sum=%0d", i, res_id, res_sum);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    held = dut_pack();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 4'd5, 4'd6, 1'b1, 4'd9, 4'd1, 1'b0);
      n_tests++;
      if ({a_ready, b_ready} !== 2'b00) begin
        n_fail++; $display("FAIL stall_ready[%0d]: got %b%b want 00", i, a_ready, b_ready);
      end
      tick();
      n_tests++;
      if (res_valid !== 1'b1 || dut_pack() !== held || dut_pack() !== sb[0]) begin
        n_fail++; $display("FAIL stall_hold[%0d]: got v=%b pack=%h want v=1 pack=%h", i, res_valid, dut_pack(), held);
      end
      $display("[TB] stall[%0d]: held pack=%h", i, dut_pack());
    end
    drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd9, 4'd1, 1'b1);
    n_tests++;
    if ({a_ready, b_ready} !== 2'b01) begin
      n_fail++; $display("FAIL release_ready: got %b%b want 01", a_ready, b_ready);
    end
    tick();
    n_tests++;
    if (res_valid !== 1'b1 || dut_pack() !== {1'b1, 5'd10, 1'b1, 1'b1}) begin
      n_fail++; $display("FAIL release_result: got pack=%h want %h", dut_pack(), {1'b1, 5'd10, 1'b1, 1'b1});
    end
    $display("[TB] release: B 9+1 -> id=%b sum=%0d", res_id, res_sum);
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 4'd4, 4'd4, 1'b1);
    n_tests++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_fail++; $display("FAIL midreset_ready: got %b%b want 00", a_ready, b_ready);
    end
    tick();
    n_tests++;
    if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL midreset_valid: got %b want 0", res_valid);
    end
    drive(1'b0, 1'b1, 4'd3, 4'd3, 1'b1, 4'd4, 4'd4, 1'b1);
    n_tests++;
    if ({a_ready, b_ready} !== 2'b10) begin
      n_fail++; $display("FAIL midreset_grant: got %b%b want 10", a_ready, b_ready);
    end
    tick();
    n_tests++;
    if (res_valid !== 1'b1 || res_id !== 1'b0 || dut_pack() !== sb[0]) begin
      n_fail++; $display("FAIL midreset_result: got v=%b id=%b want v=1 id=0", res_valid, res_id);
    end
    $display("[TB] mid-reset: first contended grant id=%b", res_id);
  endtask

  task automatic test_stats();
    drive(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(1'b0, 1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, 4'd0, 4'd0, 1'b1);
      tick();
    end
    n_tests++;
    if (grant_cnt_a !== m_cnt_a) begin
      n_fail++; $display("FAIL stats_cnt_a: got %0d want %0d", grant_cnt_a, m_cnt_a);
    end
    n_tests++;
    if (grant_cnt_b !== 8'd0) begin
      n_fail++; $display("FAIL stats_cnt_b: got %0d want 0", grant_cnt_b);
    end
    $display("[TB] stats: cnt_a=%0d cnt_b=%0d", grant_cnt_a, grant_cnt_b);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 200; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
      n_tests++;
      if ({a_ready, b_ready} !== {exp_ar, exp_br}) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b%b want %b%b", i, a_ready, b_ready, exp_ar, exp_br);
      end
      tick();
      n_tests++;
      if (res_valid !== m_full || (m_full && dut_pack() !== sb[0])) begin
        n_fail++; $display("FAIL b2b_result[%0d]: got v=%b pack=%h want v=%b pack=%h",
                           i, res_valid, dut_pack(), m_full, m_full ? sb[0] : 8'h00);
      end
      $display("[TB] b2b[%0d]: v=%b id=%b sum=%0d msb=%b gt=%b", i, res_valid, res_id, res_sum, res_msb, res_gt);
    end
  endtask

  initial begin
    m_full = 1'b0; m_prio = 1'b0; m_cnt_a = '0; m_cnt_b = '0;
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; res_ready = 1'b0;
    a_num1 = '0; a_num2 = '0; num1 = '0; num2 = '0;
    test_reset();
    test_single();
    test_carry();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_stats();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
